// File: rtl/sram_like_bridge.sv
// rtl/sram_like_bridge.sv - CPU SRAM port to SRAM-like handshake bridge with stall generation
//
// Purpose: turns a single-cycle CPU SRAM access into an SRAM-like req/addr_ok/data_ok
// transaction, stalls the pipeline until the memory answers, and holds returned read
// data while the pipeline stays frozen by other stall sources.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   cpu_en/wen/addr/wdata  CPU access (held stable while stalled), wen==0 means read
//   cpu_rdata, cpu_stall   read data and stall back to the pipeline
//   cpu_longest_stall      OR of every pipeline stall source
//   mem_req/wr/size/addr/wdata, mem_addr_ok, mem_data_ok, mem_rdata   SRAM-like port
//   perf_stall_cnt         saturating count of stalled cycles
module sram_like_bridge #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_en,
  input  logic [STRB_W-1:0] cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              cpu_longest_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_stall_cnt
);

  localparam logic [1:0] SIZE_FULL = 2'($clog2(STRB_W));

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ADDR,
    S_WAIT_DATA,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [1:0]          size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [31:0]         perf_q, perf_d;

  logic                req_wr;
  logic [1:0]          req_size;
  logic [3:0]          wen_ones;
  logic                issue;
  logic                data_hit;

  // Request attributes derived straight from the CPU inputs.
  assign req_wr = |cpu_wen;

  always_comb begin
    wen_ones = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wen_ones = wen_ones + 4'(cpu_wen[i]);
    end
  end

  // Writes with a power-of-two lane count map to that size; anything irregular
  // falls back to a full-width transfer.
  always_comb begin
    req_size = SIZE_FULL;
    if (req_wr) begin
      case (wen_ones)
        4'd1:    req_size = 2'd0;
        4'd2:    req_size = 2'd1;
        4'd4:    req_size = 2'd2;
        4'd8:    req_size = 2'd3;
        default: req_size = SIZE_FULL;
      endcase
    end
  end

  assign issue    = (state_q == S_IDLE) && cpu_en;
  assign data_hit = (state_q == S_WAIT_DATA) && mem_data_ok;

  assign mem_req   = issue || (state_q == S_WAIT_ADDR);
  assign cpu_stall = issue || (state_q == S_WAIT_ADDR) ||
                     ((state_q == S_WAIT_DATA) && !mem_data_ok);

  // In IDLE the request is presented combinationally so addr_ok can land in the
  // same cycle as cpu_en; afterwards the captured copy is replayed.
  assign mem_wr    = (state_q == S_IDLE) ? req_wr    : wr_q;
  assign mem_size  = (state_q == S_IDLE) ? req_size  : size_q;
  assign mem_addr  = (state_q == S_IDLE) ? cpu_addr  : addr_q;
  assign mem_wdata = (state_q == S_IDLE) ? cpu_wdata : wdata_q;

  // Bypass on the return cycle so the pipeline can advance without an extra stall.
  assign cpu_rdata      = data_hit ? mem_rdata : rdata_q;
  assign perf_stall_cnt = perf_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    perf_d  = perf_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_en) begin
          state_d = mem_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
        end
      end
      S_WAIT_ADDR: begin
        if (mem_addr_ok) begin
          state_d = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (mem_data_ok) begin
          // Another stall source still freezes the pipeline: park in DONE so the
          // still-asserted cpu_en is not taken as a new access.
          state_d = cpu_longest_stall ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!cpu_longest_stall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      wr_d    = req_wr;
      size_d  = req_size;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
    end

    if (data_hit) begin
      rdata_d = mem_rdata;
    end

    if (cpu_stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      perf_q  <= perf_d;
    end
  end

endmodule

// File: tb/tb_sram_like_bridge.sv
// tb/tb_sram_like_bridge.sv - randomized transaction-level bench for sram_like_bridge
module tb_sram_like_bridge;

  logic        clk;
  logic        resetn;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        cpu_longest_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic [31:0] perf_stall_cnt;

  logic [7:0]  w_wen;
  logic [63:0] w_rdata;
  logic        w_stall;
  logic        w_req;
  logic        w_wr;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [63:0] w_wdata;
  logic [31:0] w_perf;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [31:0] perf_exp   = 32'h0;

  sram_like_bridge #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_longest_stall(cpu_longest_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .perf_stall_cnt(perf_stall_cnt)
  );

  sram_like_bridge #(.DATA_W(64), .ADDR_W(32)) dut64 (
    .clk(clk), .resetn(resetn),
    .cpu_en(1'b0), .cpu_wen(w_wen), .cpu_addr(32'h0000_0008), .cpu_wdata(64'h0),
    .cpu_rdata(w_rdata), .cpu_stall(w_stall), .cpu_longest_stall(1'b0),
    .mem_req(w_req), .mem_wr(w_wr), .mem_size(w_size), .mem_addr(w_addr),
    .mem_wdata(w_wdata), .mem_addr_ok(1'b0), .mem_data_ok(1'b0),
    .mem_rdata(64'h0), .perf_stall_cnt(w_perf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transfer size from the byte-lane rules: reads and irregular writes are full width.
  function automatic logic [1:0] exp_size(input int strb, input logic [7:0] wen);
    int         n    = $countones(wen);
    logic [1:0] full = (strb == 8) ? 2'd3 : 2'd2;
    if (n == 0) return full;
    case (n)
      1:       return 2'd0;
      2:       return 2'd1;
      4:       return 2'd2;
      8:       return 2'd3;
      default: return full;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One access: addr_ok after a cycles, data_ok l cycles after acceptance, other stall
  // sources hold the pipeline for s cycles starting at the data_ok cycle, then gap idle cycles.
  task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int a, input int l, input int s,
                         input int gap);
    int last = a + l + s;
    for (int k = 0; k <= last; k++) begin
      cpu_en            = 1'b1;
      cpu_wen           = wen;
      cpu_addr          = addr;
      cpu_wdata         = wdata;
      mem_addr_ok       = (k == a) ? 1'b1 : ((k < a) ? 1'b0 : 1'($urandom_range(0, 1)));
      mem_data_ok       = (k == a + l) ? 1'b1 :
                          ((k < a) ? 1'($urandom_range(0, 1)) :
                          ((k < a + l) ? 1'b0 : 1'($urandom_range(0, 1))));
      mem_rdata         = (k == a + l) ? rdata : $urandom;
      cpu_longest_stall = (k < a + l + s);
      #3;
      check("cpu_stall", 64'(cpu_stall), 64'(k < a + l));
      check("mem_req", 64'(mem_req), 64'(k <= a));
      if (k <= a) begin
        check("mem_wr", 64'(mem_wr), 64'(wen != 4'h0));
        check("mem_size", 64'(mem_size), 64'(exp_size(4, {4'h0, wen})));
        check("mem_addr", 64'(mem_addr), 64'(addr));
        check("mem_wdata", 64'(mem_wdata), 64'(wdata));
      end
      check("cpu_rdata", 64'(cpu_rdata), 64'((k < a + l) ? last_rdata : rdata));
      tick();
    end
    last_rdata = rdata;
    perf_exp   = perf_exp + 32'(a + l);
    for (int g = 0; g < gap; g++) begin
      cpu_en            = 1'b0;
      cpu_wen           = 4'($urandom_range(0, 15));
      cpu_addr          = $urandom;
      mem_addr_ok       = 1'($urandom_range(0, 1));
      mem_data_ok       = 1'($urandom_range(0, 1));
      mem_rdata         = $urandom;
      cpu_longest_stall = 1'($urandom_range(0, 1));
      #3;
      check("idle_req", 64'(mem_req), 64'(0));
      check("idle_stall", 64'(cpu_stall), 64'(0));
      check("idle_rdata", 64'(cpu_rdata), 64'(last_rdata));
      tick();
    end
    check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(perf_exp));
  endtask

  initial begin
    resetn            = 1'b0;
    cpu_en            = 1'b0;
    cpu_wen           = 4'h0;
    cpu_addr          = 32'h0;
    cpu_wdata         = 32'h0;
    cpu_longest_stall = 1'b0;
    mem_addr_ok       = 1'b0;
    mem_data_ok       = 1'b0;
    mem_rdata         = 32'h0;
    w_wen             = 8'h0;
    #2;
    check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
    check("rst_perf", 64'(perf_stall_cnt), 64'(0));
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_cpu_stall", 64'(cpu_stall), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    run_txn(4'h0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 3, 0, 1);
    run_txn(4'hC, 32'h0000_1002, 32'hCAFE_F00D, $urandom, 2, 2, 0, 1);
    run_txn(4'h0, 32'h0000_2000, 32'h0, 32'h1234_5678, 1, 2, 5, 0);
    for (int i = 0; i < 4; i++) begin
      run_txn(4'h0, 32'h0000_3000 + 32'(4 * i), 32'h0, $urandom, 0, 1, 0, 0);
    end

    // Reset while waiting for data; the orphaned data_ok must be dropped.
    cpu_en            = 1'b1;
    cpu_wen           = 4'h0;
    cpu_addr          = 32'h0000_4000;
    mem_addr_ok       = 1'b1;
    mem_data_ok       = 1'b0;
    cpu_longest_stall = 1'b1;
    #3;
    check("abort_issue_req", 64'(mem_req), 64'(1));
    tick();
    mem_addr_ok = 1'b0;
    #3;
    check("abort_wait_stall", 64'(cpu_stall), 64'(1));
    resetn = 1'b0;
    cpu_en = 1'b0;
    #1;
    check("abort_rdata", 64'(cpu_rdata), 64'(0));
    check("abort_perf", 64'(perf_stall_cnt), 64'(0));
    check("abort_req", 64'(mem_req), 64'(0));
    check("abort_stall", 64'(cpu_stall), 64'(0));
    tick();
    resetn            = 1'b1;
    mem_data_ok       = 1'b1;
    mem_rdata         = 32'hAAAA_5555;
    cpu_longest_stall = 1'b0;
    #3;
    check("late_ok_rdata", 64'(cpu_rdata), 64'(0));
    check("late_ok_stall", 64'(cpu_stall), 64'(0));
    tick();
    mem_data_ok = 1'b0;
    #3;
    check("late_ok_held", 64'(cpu_rdata), 64'(0));
    check("late_ok_perf", 64'(perf_stall_cnt), 64'(0));
    last_rdata = 32'h0;
    perf_exp   = 32'h0;

    for (int t = 0; t < 40; t++) begin
      logic [3:0] wen;
      wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      run_txn(wen, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end

    // 64-bit configuration: request attributes are presented combinationally in IDLE.
    for (int j = 0; j < 6; j++) begin
      logic [7:0] pats [6];
      pats = '{8'h00, 8'hFF, 8'h0F, 8'h03, 8'h01, 8'h07};
      w_wen = pats[j];
      #3;
      check("w64_size", 64'(w_size), 64'(exp_size(8, pats[j])));
      check("w64_wr", 64'(w_wr), 64'(pats[j] != 8'h00));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
